// File: rtl/line_dec_pkg.sv
// Shared state encodings, width helper and output-polarity helpers for the line decoder.
package line_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Level of an asserted / idle output line for the given polarity.
  function automatic logic DEC_ACTIVE(input logic active_low);
    return ~active_low;
  endfunction

  function automatic logic DEC_INACTIVE(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder.
// Latency: 0 cycles (pure logic).
// Backpressure: none; output follows sel continuously.
module decoder_core #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   onehot
);

  generate
    if (SEL_W == 1) begin : g_leaf
      assign onehot = {sel[0], ~sel[0]};
    end else begin : g_split
      // Upper and lower select halves are decoded separately; every output
      // line is the AND of one line from each half.
      localparam int HI_W = SEL_W / 2;
      localparam int LO_W = SEL_W - HI_W;

      logic [2**HI_W-1:0] hi_dec;
      logic [2**LO_W-1:0] lo_dec;

      decoder_core #(.SEL_W(HI_W)) u_hi (
        .sel    (sel[SEL_W-1:LO_W]),
        .onehot (hi_dec)
      );

      decoder_core #(.SEL_W(LO_W)) u_lo (
        .sel    (sel[LO_W-1:0]),
        .onehot (lo_dec)
      );

      for (genvar h = 0; h < 2**HI_W; h++) begin : g_hi
        for (genvar l = 0; l < 2**LO_W; l++) begin : g_lo
          assign onehot[h*(2**LO_W) + l] = hi_dec[h] & lo_dec[l];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/line_decoder_seq.sv
// Registered line decoder with direct-decode and auto-stepping scan modes.
// Latency: 1 clock from any input to all outputs.
// Backpressure: none; en=0 drops to idle with all lines inactive.
module line_decoder_seq
  import line_dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   d_out,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int   OUT_W = 2**SEL_W;
  localparam int   CNT_W = clog2(SCAN_DIV) + 1;
  localparam logic POL   = (ACTIVE_LOW != 0);
  localparam logic ACT   = DEC_ACTIVE(POL);
  localparam logic INACT = DEC_INACTIVE(POL);

  state_t             state, state_n;
  logic [CNT_W-1:0]   div_cnt, cnt_n;
  logic [SEL_W-1:0]   idx_n;
  logic               valid_n, wrap_n;
  logic [OUT_W-1:0]   onehot, d_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      d_out   <= {OUT_W{INACT}};
    end else begin
      state   <= state_n;
      div_cnt <= cnt_n;
      idx     <= idx_n;
      valid   <= valid_n;
      wrap    <= wrap_n;
      d_out   <= d_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = div_cnt;
    idx_n   = idx;
    valid_n = valid;
    wrap_n  = 1'b0;

    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      valid_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mode) begin
            state_n = ST_SCAN;
            cnt_n   = '0;
            valid_n = 1'b1;
            if (load) idx_n = sel;
          end else if (load) begin
            state_n = ST_DECODE;
            idx_n   = sel;
            valid_n = 1'b1;
          end
        end
        ST_DECODE: begin
          valid_n = 1'b1;
          if (load) idx_n = sel;
          if (mode) begin
            state_n = ST_SCAN;
            cnt_n   = '0;
          end
        end
        ST_SCAN: begin
          valid_n = 1'b1;
          if (!mode) begin
            state_n = ST_DECODE;
            cnt_n   = '0;
            if (load) idx_n = sel;
          end else if (load) begin
            // A reload restarts the step period and suppresses any step due now.
            idx_n = sel;
            cnt_n = '0;
          end else if (div_cnt == CNT_W'(SCAN_DIV - 1)) begin
            idx_n  = idx + SEL_W'(1);
            cnt_n  = '0;
            wrap_n = (idx == SEL_W'(OUT_W - 1));
          end else begin
            cnt_n = div_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          valid_n = 1'b0;
        end
      endcase
    end
  end

  decoder_core #(.SEL_W(SEL_W)) u_core (
    .sel    (idx_n),
    .onehot (onehot)
  );

  always_comb begin
    d_n = {OUT_W{INACT}};
    if (valid_n) d_n = (onehot & {OUT_W{ACT}}) | (~onehot & {OUT_W{INACT}});
  end

endmodule
